// File: rtl/pdm_mic_model.sv
// rtl/pdm_mic_model.sv - PCM-to-PDM first-order sigma-delta transmitter with sample FIFO
module pdm_mic_model #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          en,
    input  logic          mclk,
    input  logic          ce_pcm,
    input  logic          s_valid,
    input  logic [15:0]   s_data,
    output logic          s_ready,
    input  logic          clr_underrun,
    output logic          pdm_o,
    output logic [AW:0]   level,
    output logic          underrun
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   cur_q, cur_d;
    logic [15:0]   acc_q, acc_d;
    logic          pdm_q, pdm_d;
    logic          underrun_q, underrun_d;
    logic          mclk_q;

    logic          rise, push, pop, empty;
    logic [15:0]   x;
    logic [16:0]   sum;

    always_comb begin
        empty   = (level_q == '0);
        s_ready = (level_q != (AW+1)'(DEPTH));
        rise    = mclk & ~mclk_q;
        push    = s_valid & s_ready;
        pop     = ce_pcm & en & ~empty;
        // Two's complement to offset binary: midscale maps to 0x8000
        x       = {~cur_q[15], cur_q[14:0]};
        sum     = {1'b0, acc_q} + {1'b0, x};

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)
            level_d = level_q + (AW+1)'(1);
        else if (pop && !push)
            level_d = level_q - (AW+1)'(1);

        cur_d = cur_q;
        acc_d = acc_q;
        pdm_d = pdm_q;
        if (!en) begin
            cur_d = '0;
            acc_d = '0;
            pdm_d = 1'b0;
        end else begin
            if (pop)
                cur_d = mem_q[rd_ptr_q];
            // The rise uses the current cur_q; a same-cycle pop only affects later rises
            if (rise) begin
                acc_d = sum[15:0];
                pdm_d = sum[16];
            end
        end

        underrun_d = underrun_q;
        if (ce_pcm && en && empty)
            underrun_d = 1'b1;
        else if (clr_underrun)
            underrun_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cur_q      <= '0;
            acc_q      <= '0;
            pdm_q      <= 1'b0;
            underrun_q <= 1'b0;
            mclk_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            pdm_q      <= pdm_d;
            underrun_q <= underrun_d;
            mclk_q     <= mclk;
        end
    end

    // Storage needs no reset; the pointers define which words are live
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && push)
            mem_q[wr_ptr_q] <= s_data;
    end

    assign pdm_o    = pdm_q;
    assign level    = level_q;
    assign underrun = underrun_q;

endmodule
